// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the decode pipeline and the ALU execute unit.
// master = upstream/downstream pipeline side, slave = the execute unit.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic            ready_in;
  logic [3:0]      ALUFn;
  logic [1:0]      BranchOp;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            valid_out;
  logic            ready_out;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            branch_taken;

  modport master (
    output valid_in, ALUFn, BranchOp, op_a, op_b, ready_out,
    input  ready_in, valid_out, result, zero, branch_taken
  );

  modport slave (
    input  valid_in, ALUFn, BranchOp, op_a, op_b, ready_out,
    output ready_in, valid_out, result, zero, branch_taken
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/shift/add/sub with branch resolution, and an
// iterative radix-2 shift-add multiplier / restoring signed divider behind valid/ready.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_unit_if.slave bus
);

  localparam int CW  = $clog2(XLEN + 1);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] F_AND = 4'b0000;
  localparam logic [3:0] F_OR  = 4'b0001;
  localparam logic [3:0] F_ADD = 4'b0010;
  localparam logic [3:0] F_XOR = 4'b0011;
  localparam logic [3:0] F_SLL = 4'b0100;
  localparam logic [3:0] F_MUL = 4'b0101;
  localparam logic [3:0] F_SUB = 4'b0110;
  localparam logic [3:0] F_DIV = 4'b0111;
  localparam logic [3:0] F_SRL = 4'b1000;
  localparam logic [3:0] F_REM = 4'b1001;

  localparam logic [1:0] M_MUL = 2'd0;
  localparam logic [1:0] M_DIV = 2'd1;
  localparam logic [1:0] M_REM = 2'd2;

  localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic            w_ready_in;
  logic            w_valid_out;
  logic            w_accept;
  logic            w_start_iter;

  logic [XLEN-1:0] w_diff;
  logic            w_lt;
  logic            w_b_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_single_res;
  logic            w_single_br;

  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_mop;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_x;
  logic [XLEN-1:0] r_y;
  logic            r_neg_q;
  logic            r_neg_r;

  logic [XLEN-1:0] w_mul_acc;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic            w_fit;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_final;

  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_branch;

  // ---- single-cycle datapath and divide special-case detection ----
  always_comb begin
    w_diff       = bus.op_a - bus.op_b;
    w_lt         = $signed(bus.op_a) < $signed(bus.op_b);
    w_b_zero     = (bus.op_b == '0);
    w_ovf        = (bus.op_a == W_MIN) && (bus.op_b == '1);
    w_abs_a      = bus.op_a[XLEN-1] ? f_neg(bus.op_a) : bus.op_a;
    w_abs_b      = bus.op_b[XLEN-1] ? f_neg(bus.op_b) : bus.op_b;
    w_single_res = '0;
    w_single_br  = 1'b0;
    case (bus.ALUFn)
      F_AND: w_single_res = bus.op_a & bus.op_b;
      F_OR:  w_single_res = bus.op_a | bus.op_b;
      F_ADD: w_single_res = bus.op_a + bus.op_b;
      F_XOR: w_single_res = bus.op_a ^ bus.op_b;
      F_SLL: w_single_res = bus.op_a << bus.op_b[SHW-1:0];
      F_SRL: w_single_res = bus.op_a >> bus.op_b[SHW-1:0];
      F_SUB: begin
        w_single_res = w_diff;
        // BLT/BGE use the true signed compare, not the sign of the wrapped difference
        case (bus.BranchOp)
          2'b00:   w_single_br = (w_diff == '0);
          2'b01:   w_single_br = (w_diff != '0);
          2'b10:   w_single_br = w_lt;
          default: w_single_br = !w_lt;
        endcase
      end
      F_DIV: w_single_res = w_b_zero ? '1 : W_MIN;
      F_REM: w_single_res = w_b_zero ? bus.op_a : '0;
      default: w_single_res = '0;
    endcase
  end

  assign w_start_iter = (bus.ALUFn == F_MUL) ||
                        (((bus.ALUFn == F_DIV) || (bus.ALUFn == F_REM)) && !(w_b_zero || w_ovf));

  // ---- iterative step: shift-add multiply / restoring divide on magnitudes ----
  always_comb begin
    w_mul_acc = r_acc + (r_y[0] ? r_x : '0);
    w_shift   = {r_acc, r_y[XLEN-1]};
    w_trial   = w_shift - {1'b0, r_x};
    w_fit     = ~w_trial[XLEN];
    w_rem_nxt = w_fit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    w_quo_nxt = {r_y[XLEN-2:0], w_fit};
    case (r_mop)
      M_MUL:   w_final = w_mul_acc;
      M_DIV:   w_final = r_neg_q ? f_neg(w_quo_nxt) : w_quo_nxt;
      default: w_final = r_neg_r ? f_neg(w_rem_nxt) : w_rem_nxt;
    endcase
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.valid_in) w_next = w_start_iter ? S_BUSY : S_DONE;
      S_BUSY: if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE: if (bus.ready_out) begin
        if (bus.valid_in) w_next = w_start_iter ? S_BUSY : S_DONE;
        else              w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    w_ready_in  = 1'b0;
    w_valid_out = 1'b0;
    case (r_state)
      S_IDLE: w_ready_in = 1'b1;
      S_DONE: begin
        w_valid_out = 1'b1;
        w_ready_in  = bus.ready_out;
      end
      default: ;
    endcase
  end

  assign w_accept = bus.valid_in && w_ready_in;

  // ---- operand capture, iteration and result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mop    <= M_MUL;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_branch <= 1'b0;
    end else if (w_accept) begin
      if (w_start_iter) begin
        r_cnt <= CW'(XLEN);
        r_acc <= '0;
        if (bus.ALUFn == F_MUL) begin
          r_mop <= M_MUL;
          r_x   <= bus.op_a;
          r_y   <= bus.op_b;
        end else begin
          r_mop   <= (bus.ALUFn == F_DIV) ? M_DIV : M_REM;
          r_x     <= w_abs_b;
          r_y     <= w_abs_a;
          r_neg_q <= bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1];
          r_neg_r <= bus.op_a[XLEN-1];
        end
      end else begin
        r_result <= w_single_res;
        r_zero   <= (w_single_res == '0);
        r_branch <= w_single_br;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_mop == M_MUL) begin
        r_acc <= w_mul_acc;
        r_x   <= r_x << 1;
        r_y   <= r_y >> 1;
      end else begin
        r_acc <= w_rem_nxt;
        r_y   <= w_quo_nxt;
      end
      // last iteration also applies the sign fixup and publishes the result
      if (r_cnt == CW'(1)) begin
        r_result <= w_final;
        r_zero   <= (w_final == '0);
        r_branch <= 1'b0;
      end
    end
  end

  assign bus.ready_in     = w_ready_in;
  assign bus.valid_out    = w_valid_out;
  assign bus.result       = r_result;
  assign bus.zero         = r_zero;
  assign bus.branch_taken = r_branch;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the ALU control decoder's ALUFn and BranchOp codes.
- Computes the 32-bit result, the zero flag and the branch decision for every ALUFn code.
- Logic, shift, ADD and SUB finish in one cycle.
- MUL, DIV and REM use an iterative radix-2 datapath. The pipeline sees a valid/ready handshake on both the operand side and the result side.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  operands and codes present
ready_in  output  1  unit can accept; high in IDLE, or in DONE when ready_out is high
ALUFn  input  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 MUL, 0110 SUB, 0111 DIV, 1000 SRL, 1001 REM
BranchOp  input  2  00 BEQ, 01 BNE, 10 BLT, 11 BGE (used only with SUB)
op_a  input  XLEN  rs1 value
op_b  input  XLEN  rs2 value
valid_out  output  1  result valid
ready_out  input  1  downstream accepts result
result  output  XLEN  registered result
zero  output  1  registered, result==0
branch_taken  output  1  registered branch decision

Behaviour:
- Reset (async, rst_n low): state=IDLE; valid_out=0, result=0, zero=0, branch_taken=0; iteration counter and partial registers cleared. Reset mid-operation aborts it and no valid_out is produced.
- Accept: valid_in && ready_in at a rising edge. ALUFn, BranchOp, op_a and op_b are captured internally. Inputs are don't-care afterwards.
- States: IDLE, BUSY, DONE.
  - IDLE + accept of a single-cycle op -> DONE, with result registered at the same edge (latency 1).
  - IDLE + accept of MUL/DIV/REM -> BUSY, counter=XLEN.
  - BUSY: one iteration per cycle, counter decrements; counter reaching 1 -> DONE with final result. valid_out rises exactly XLEN+1 cycles after the accepting edge (33 for XLEN=32).
  - DONE: valid_out=1; result, zero and branch_taken are held stable while ready_out=0. If ready_out=1 and no new accept -> IDLE. If ready_out=1 and an accept occurs in the same cycle, the result retires and the new op starts (pass-through; back-to-back single-cycle ops sustain one per cycle).
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLL/SRL are logical and shift by op_b[4:0].
  - MUL returns the low XLEN bits of the product, via shift-add iteration.
  - DIV/REM are signed (RISC-V semantics), via magnitude restoring division with sign fixup on the final iteration. Quotient truncates toward zero; remainder takes the sign of the dividend.
- DIV/REM special cases: detected at accept, go straight to DONE with latency 1.
  - Divide by zero: DIV -> all ones; REM -> op_a.
  - Overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Undefined ALUFn codes: result=0, zero=1, branch_taken=0, latency 1.
- zero = (result==0), registered with result.
- branch_taken: only for ALUFn=SUB, otherwise 0.
  - BEQ: taken when zero.
  - BNE: taken when !zero.
  - BLT: taken when signed op_a<op_b, computed from the true sign, not the wrapped difference.
  - BGE: the complement of BLT.
- valid_in while BUSY, or while DONE with ready_out=0: not accepted (ready_in=0). The upstream stage must hold its inputs.

Test Plan:
1. Reset, then ADD 0x7FFFFFFF+1, ready_out=1 -> valid_out after 1 cycle, result=0x80000000, zero=0; ready_in high every cycle.
2. SUB 5-5 with BranchOp=BEQ -> result=0, zero=1, branch_taken=1. SUB 0xFFFFFFFF(-1) vs 1 with BLT -> branch_taken=1; same operands with BGE -> branch_taken=0.
3. MUL 0x00010003 x 0x00020005 -> valid_out exactly 33 cycles after accept, result=0x000B000F; ready_in=0 during BUSY; a new valid_in during BUSY is ignored.
4. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIV 7/0 -> 0xFFFFFFFF with latency 1. REM 7/0 -> 7. DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
5. Backpressure: complete SLL 1<<31 with ready_out=0 for 5 cycles -> result=0x80000000 held, valid_out stays high, ready_in=0. Raise ready_out together with a new valid_in (SRL 0x80000000>>4) -> next cycle result=0x08000000.
6. Assert rst_n=0 at cycle 10 of a DIV -> outputs return to 0 immediately, state IDLE, and no valid_out appears afterwards.
